// File: rtl/if_stage_param.sv
// Instruction-fetch stage: PC register, writable instruction memory and registered IR.
// Optional macro IF_SQUASH_EN replaces the instruction fetched on a redirect edge with a bubble.
module if_stage_param #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     IMEM_DEPTH = 128,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] PC_LIMIT   = XLEN'(332),
    parameter logic [XLEN-1:0] NOP_WORD   = XLEN'(32'h20)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall_i,
    input  logic                          ex_br_taken_i,
    input  logic [XLEN-1:0]               ex_br_target_i,
    input  logic                          id_jmp_i,
    input  logic [27:0]                   id_jmp_imm_i,
    input  logic                          imem_we_i,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr_i,
    input  logic [XLEN-1:0]               imem_wdata_i,
    output logic [XLEN-1:0]               pc_o,
    output logic [XLEN-1:0]               ir_o,
    output logic                          valid_o,
    output logic                          halted_o
);

    localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);
    localparam int unsigned WA_W  = XLEN - 2;

    logic [XLEN-1:0]  r_imem [IMEM_DEPTH];
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_ir;
    logic             r_valid;
    logic             r_halted;

    logic [IDX_W-1:0] w_idx;
    logic [XLEN-1:0]  w_fetch;
    logic [XLEN-1:0]  w_next_pc;
    logic [XLEN-1:0]  w_next_ir;
    logic             w_next_valid;
    logic             w_next_halted;
    logic             w_redirect;
    logic             w_unused;

    // Target low bits are always forced to zero, so they are never consumed.
    assign w_unused = &{1'b0, ex_br_target_i[1:0], id_jmp_imm_i[1:0]};

    // Word read; any word address beyond the memory returns a NOP.
    assign w_idx   = r_pc[IDX_W+1:2];
    assign w_fetch = (r_pc[XLEN-1:2] < WA_W'(IMEM_DEPTH)) ? r_imem[w_idx] : NOP_WORD;

    // Next-state selection: branch > jump > stall > halted > sequential.
    always_comb begin
        w_next_pc     = r_pc;
        w_next_ir     = r_ir;
        w_next_valid  = r_valid;
        w_next_halted = r_halted;
        w_redirect    = 1'b0;

        if (ex_br_taken_i) begin
            w_next_pc  = {ex_br_target_i[XLEN-1:2], 2'b00};
            w_redirect = 1'b1;
        end else if (id_jmp_i) begin
            w_next_pc  = {r_pc[XLEN-1:28], id_jmp_imm_i[27:2], 2'b00};
            w_redirect = 1'b1;
        end

        if (w_redirect) begin
`ifdef IF_SQUASH_EN
            w_next_ir    = NOP_WORD;
            w_next_valid = 1'b0;
`else
            w_next_ir    = w_fetch;
            w_next_valid = 1'b1;
`endif
            w_next_halted = (w_next_pc >= PC_LIMIT);
        end else if (!stall_i) begin
            if (r_halted) begin
                w_next_ir    = NOP_WORD;
                w_next_valid = 1'b0;
            end else begin
                w_next_pc     = r_pc + XLEN'(4);
                w_next_ir     = w_fetch;
                w_next_valid  = 1'b1;
                w_next_halted = (w_next_pc >= PC_LIMIT);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_ir     <= NOP_WORD;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_pc     <= w_next_pc;
            r_ir     <= w_next_ir;
            r_valid  <= w_next_valid;
            r_halted <= w_next_halted;
        end
    end

    // Memory contents survive reset; a same-cycle fetch sees the old word.
    always_ff @(posedge clk) begin
        if (imem_we_i) begin
            r_imem[imem_waddr_i] <= imem_wdata_i;
        end
    end

    assign pc_o     = r_pc;
    assign ir_o     = r_ir;
    assign valid_o  = r_valid;
    assign halted_o = r_halted;

endmodule
